// File: rtl/posit_binary_if.sv
// posit_binary_if
//   Handshake bundle for the posit<8,1> to 16-bit integer decoder.
//   Input side:  in_valid / in_ready / posit_in  (producer -> decoder)
//   Output side: out_valid / out_ready / binary_out / nar  (decoder -> consumer)
//   master: the producer/consumer environment around the decoder.
//   slave:  the decoder itself.
interface posit_binary_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  posit_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] binary_out;
  logic        nar;

  modport master (
    output in_valid, posit_in, out_ready,
    input  in_ready, out_valid, binary_out, nar
  );

  modport slave (
    input  in_valid, posit_in, out_ready,
    output in_ready, out_valid, binary_out, nar
  );
endinterface

// File: rtl/posit_binary.sv
// posit_binary
//   Multi-cycle decoder from an 8-bit posit<8,1> word to a 16-bit signed
//   two's-complement integer, truncated toward zero. The regime field is
//   scanned serially, one bit per cycle; only one conversion is in flight.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - posit_binary_if.slave: in_valid/in_ready/posit_in accept side,
//            out_valid/out_ready/binary_out/nar result side
// Parameters:
//   NAR_VALUE - value presented on binary_out for the NaR input (0x80)
module posit_binary #(
  parameter logic [15:0] NAR_VALUE = 16'h8000
) (
  input  logic           clk,
  input  logic           rst_n,
  posit_binary_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [6:0]  w_q, w_d;
  logic        run_bit_q, run_bit_d;
  logic [2:0]  run_q, run_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] binary_out_q, binary_out_d;
  logic        nar_q, nar_d;

  logic        accept;
  logic [6:0]  w_in;
  logic        scan_bit;
  logic        first_bit;
  logic        is_term;
  logic signed [4:0] k;
  logic signed [4:0] scale;
  logic [4:0]  mant;
  logic [12:0] magnitude;
  logic [15:0] result;

  assign accept = bus.in_valid && (state_q == IDLE);

  // Magnitude of the posit body. For any input other than 0x80 the negated
  // word has a zero MSB, so the low 7 bits of the two's complement suffice.
  assign w_in = bus.posit_in[7] ? (~bus.posit_in[6:0] + 7'd1) : bus.posit_in[6:0];

  // The scanner shifts w left each cycle, so the bit under inspection is
  // always w_q[6]; after scanning, the remaining exponent/fraction bits sit
  // left-aligned with zeros shifted in behind them.
  assign scan_bit  = w_q[6];
  assign first_bit = (cnt_q == 3'd0);
  assign is_term   = !first_bit && (scan_bit != run_bit_q);

  // Scale = 2k + e, where k comes from the regime run length. A negative
  // scale means the value is below one and truncates to zero.
  always_comb begin
    k         = run_bit_q ? (signed'({2'b00, run_q}) - 5'sd1) : -signed'({2'b00, run_q});
    scale     = (k <<< 1) + signed'({4'b0000, w_q[6]});
    mant      = {1'b1, w_q[5:2]};
    magnitude = 13'd0;
    if (!scale[4]) begin
      magnitude = 13'(({12'd0, mant} << scale[3:0]) >> 4);
    end
    result = sign_q ? (16'd0 - {3'b000, magnitude}) : {3'b000, magnitude};
  end

  // Next-state and datapath updates; every register holds unless its state
  // says otherwise.
  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    w_d          = w_q;
    run_bit_d    = run_bit_q;
    run_d        = run_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    binary_out_d = binary_out_q;
    nar_d        = nar_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d    = bus.posit_in[7];
          w_d       = w_in;
          run_bit_d = 1'b0;
          run_d     = 3'd0;
          cnt_d     = 3'd0;
          if (bus.posit_in == 8'h00) begin
            binary_out_d = 16'h0000;
            nar_d        = 1'b0;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else if (bus.posit_in == 8'h80) begin
            binary_out_d = NAR_VALUE;
            nar_d        = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        cnt_d = cnt_q + 3'd1;
        w_d   = {w_q[5:0], 1'b0};
        if (first_bit) begin
          run_bit_d = scan_bit;
        end
        if (!is_term) begin
          run_d = run_q + 3'd1;
        end
        // Stop once the terminator is consumed or the last body bit is used.
        if (is_term || (cnt_q == 3'd6)) begin
          state_d = CALC;
        end
      end

      CALC: begin
        binary_out_d = result;
        nar_d        = 1'b0;
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any conversion and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sign_q       <= 1'b0;
      w_q          <= 7'd0;
      run_bit_q    <= 1'b0;
      run_q        <= 3'd0;
      cnt_q        <= 3'd0;
      out_valid_q  <= 1'b0;
      binary_out_q <= 16'h0000;
      nar_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      w_q          <= w_d;
      run_bit_q    <= run_bit_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      binary_out_q <= binary_out_d;
      nar_q        <= nar_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.binary_out = binary_out_q;
  assign bus.nar        = nar_q;

endmodule

// File: tb/tb_posit_binary.sv
// tb_posit_binary
//   Scoreboard bench for posit_binary: expected results are queued when a
//   word is accepted and popped when the decoder presents its result.
module tb_posit_binary;

  typedef struct {
    logic [15:0] val;
    logic        nar;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  posit_binary_if bus ();

  posit_binary #(.NAR_VALUE(16'h8000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: walk the regime, then evaluate the value in
  // real arithmetic and truncate toward zero.
  function automatic exp_t model(input logic [7:0] p);
    exp_t r;
    logic [7:0] w;
    logic rb;
    int i, run, s, k, e, f, sc, mag;
    real v;
    r.val = 16'h0000;
    r.nar = 1'b0;
    r.lat = 1;
    if (p == 8'h00) return r;
    if (p == 8'h80) begin
      r.val = 16'h8000;
      r.nar = 1'b1;
      return r;
    end
    w   = p[7] ? (8'd0 - p) : p;
    rb  = w[6];
    i   = 6;
    run = 0;
    while (i >= 0 && w[i[2:0]] == rb) begin
      run++;
      i--;
    end
    s = (i >= 0) ? run + 1 : run;
    if (i >= 0) i--;
    k = rb ? run - 1 : -run;
    e = 0;
    if (i >= 0) begin
      e = int'(w[i[2:0]]);
      i--;
    end
    f = 0;
    for (int j = 0; j < 4; j++) begin
      f = f * 2;
      if (i >= 0) begin
        f = f + int'(w[i[2:0]]);
        i--;
      end
    end
    sc = 2 * k + e;
    v  = 1.0 + real'(f) / 16.0;
    if (sc >= 0) repeat (sc) v = v * 2.0;
    else         repeat (-sc) v = v / 2.0;
    mag   = $rtoi(v);
    r.val = p[7] ? 16'(-mag) : 16'(mag);
    r.lat = s + 2;
    return r;
  endfunction

  // Present a word, wait (bounded) for in_ready, push its expectation at the
  // accepting edge. Called and returns at posedge+1.
  task automatic do_accept(input logic [7:0] p, input exp_t e);
    int n;
    n = 0;
    bus.posit_in = p;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_timeout p=%02h: in_ready=%b expected 1", p, bus.in_ready);
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid, the accepting edge being edge 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_transfer();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.posit_in = 8'h00;
    bus.out_ready = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.binary_out !== 16'h0000 || bus.nar !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b out=%h nar=%b expected 0/0000/0",
               bus.out_valid, bus.binary_out, bus.nar);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    exp_t e;
    int lat;
    bus.out_ready = 1'b1;
    do_accept(8'h40, '{16'h0001, 1'b0, 4});
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy: in_ready=%b expected 0", bus.in_ready);
    end
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || lat != e.lat) begin
      errors++;
      $display("[TB] FAIL basic_latency: got v=%b lat=%0d expected v=1 lat=%0d", bus.out_valid, lat, e.lat);
    end
    checks++;
    if (bus.binary_out !== e.val || bus.nar !== e.nar) begin
      errors++;
      $display("[TB] FAIL basic_value: got %h nar=%b expected %h nar=%b", bus.binary_out, bus.nar, e.val, e.nar);
    end
    do_transfer();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_transfer: got v=%b rdy=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_sequence();
    logic [7:0]  seq_p   [9] = '{8'h50, 8'h48, 8'h6C, 8'h7F, 8'hC0, 8'h94, 8'h20, 8'h00, 8'h80};
    logic [15:0] seq_val [9] = '{16'h0002, 16'h0001, 16'h000C, 16'h1000, 16'hFFFF, 16'hFFF4, 16'h0000, 16'h0000, 16'h8000};
    logic        seq_nar [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          seq_lat [9] = '{4, 4, 5, 9, 4, 5, 4, 1, 1};
    exp_t e;
    int lat;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      e.val = seq_val[n];
      e.nar = seq_nar[n];
      e.lat = seq_lat[n];
      do_accept(seq_p[n], e);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || lat != e.lat) begin
        errors++;
        $display("[TB] FAIL seq_latency p=%02h: got v=%b lat=%0d expected lat=%0d", seq_p[n], bus.out_valid, lat, e.lat);
      end
      checks++;
      if (bus.binary_out !== e.val || bus.nar !== e.nar) begin
        errors++;
        $display("[TB] FAIL seq_value p=%02h: got %h nar=%b expected %h nar=%b", seq_p[n], bus.binary_out, bus.nar, e.val, e.nar);
      end
      do_transfer();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    bus.out_ready = 1'b0;
    do_accept(8'h60, '{16'h0004, 1'b0, 5});
    // A competing word while busy must be ignored.
    bus.posit_in = 8'h7F;
    bus.in_valid = 1'b1;
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || lat != e.lat || bus.binary_out !== e.val) begin
      errors++;
      $display("[TB] FAIL bp_result: got v=%b lat=%0d out=%h expected lat=%0d out=%h", bus.out_valid, lat, bus.binary_out, e.lat, e.val);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.binary_out !== 16'h0004 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle=%0d: got v=%b out=%h rdy=%b expected 1/0004/0", c, bus.out_valid, bus.binary_out, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    do_transfer();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_transfer: out_valid=%b expected 0", bus.out_valid);
    end
    do_accept(8'h48, '{16'h0001, 1'b0, 4});
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || lat != e.lat || bus.binary_out !== e.val) begin
      errors++;
      $display("[TB] FAIL bp_next: got v=%b lat=%0d out=%h expected lat=%0d out=%h", bus.out_valid, lat, bus.binary_out, e.lat, e.val);
    end
    do_transfer();
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    int lat;
    bus.out_ready = 1'b1;
    do_accept(8'h7F, model(8'h7F));
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.binary_out !== 16'h0000 || bus.nar !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: got v=%b out=%h nar=%b rdy=%b expected 0/0000/0/1",
               bus.out_valid, bus.binary_out, bus.nar, bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_accept(8'h40, '{16'h0001, 1'b0, 4});
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || lat != e.lat || bus.binary_out !== e.val || bus.nar !== e.nar) begin
      errors++;
      $display("[TB] FAIL post_reset: got v=%b lat=%0d out=%h expected lat=%0d out=%h", bus.out_valid, lat, bus.binary_out, e.lat, e.val);
    end
    do_transfer();
  endtask

  task automatic test_exhaustive();
    exp_t e;
    int lat;
    for (int n = 0; n < 256; n++) begin
      bus.out_ready = 1'b0;
      do_accept(8'(n), model(8'(n)));
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || lat != e.lat) begin
        errors++;
        $display("[TB] FAIL sweep_latency p=%02h: got v=%b lat=%0d expected lat=%0d", n, bus.out_valid, lat, e.lat);
      end
      checks++;
      if (bus.binary_out !== e.val || bus.nar !== e.nar) begin
        errors++;
        $display("[TB] FAIL sweep_value p=%02h: got %h nar=%b expected %h nar=%b", n, bus.binary_out, bus.nar, e.val, e.nar);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.binary_out !== e.val) begin
          errors++;
          $display("[TB] FAIL sweep_stall p=%02h: got v=%b out=%h expected 1/%h", n, bus.out_valid, bus.binary_out, e.val);
        end
      end
      do_transfer();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep_transfer p=%02h: out_valid=%b expected 0", n, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    $display("[TB] posit_binary bench start");
    test_reset();
    test_basic();
    test_sequence();
    test_backpressure();
    test_reset_mid_scan();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/posit_binary.md
Name: posit_binary

Overview:
- Multi-cycle decoder from 8-bit posit (posit<8,1>: 1 sign bit, variable-length regime, es=1 exponent bit, remaining fraction bits) to a 16-bit signed two's-complement integer.
- Inverse direction of the binary-to-posit encoder in the posit ALU datapath.
- Serial regime scanner FSM with valid/ready handshakes on input and output; one conversion in flight.

Parameters:
- NAR_VALUE, 16'h8000, value driven on binary_out when the input is NaR (0x80).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  posit_in is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- posit_in  input  8  posit word; sampled only on accept (in_valid & in_ready).
- out_valid  output  1  binary_out/nar valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- binary_out  output  16  signed integer result, truncated toward zero.
- nar  output  1  result is Not-a-Real.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, binary_out=0, nar=0; in_ready=1 once in IDLE. Reset mid-conversion aborts it; no output is produced.
- States: IDLE, SCAN, CALC, DONE.
- IDLE -> on accept, latch sign=posit_in[7] and w = sign ? two's complement of posit_in : posit_in.
  - If posit_in==0x00, go to DONE with result 0.
  - If posit_in==0x80, go to DONE with result NAR_VALUE and nar=1.
  - Otherwise go to SCAN.
- SCAN: consumes w[6:0] MSB-first, one bit per cycle.
  - The run bit is the first bit; count identical bits.
  - Stop after consuming the first opposite (terminator) bit, or after all 7 bits.
  - S = min(run+1, 7) cycles; then go to CALC.
- CALC (1 cycle):
  - k = run-1 if run bit=1, else -run.
  - e = next bit after the terminator, 0 if none left.
  - f = following bits left-aligned into 4 bits, zero-padded.
  - scale = 2k+e, range -12..12.
  - mant = {1,f} (5 bits); magnitude = floor(mant * 2^(scale-4)).
  - magnitude = 0 when scale < 0; maximum magnitude is 4096.
  - binary_out = sign ? -magnitude : magnitude; nar=0. Go to DONE.
- DONE: out_valid=1; binary_out and nar stable. On out_valid & out_ready, go to IDLE and clear out_valid on that edge.
- Latency: out_valid rises S+2 edges after the accepting edge for normal inputs; 1 edge after for 0x00 and 0x80.
- in_ready=0 in SCAN/CALC/DONE. in_valid and posit_in are ignored while busy. Accept is possible again the cycle after the output transfer (no overlap).
- out_ready while out_valid=0 has no effect. out_valid never drops without a transfer.

Test Plan:
- Reset then posit_in=0x40, in_valid pulse, out_ready=1 -> binary_out=0x0001, nar=0, out_valid 4 edges after accept (S=2); in_ready low until transfer.
- Sequence 0x50, 0x48, 0x6C, 0x7F -> 2, 1 (1.5 truncated), 12, 4096. 0x7F is full regime: S=7, latency 9 edges.
- Negative inputs: 0xC0 -> 0xFFFF (-1); 0x94 (two's complement 0x6C) -> 0xFFF4 (-12); 0x20 (0.25) -> 0x0000.
- Specials: 0x00 -> 0x0000, nar=0; 0x80 -> 0x8000, nar=1; each out_valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 5 cycles after 0x60 -> out_valid and binary_out=4 stable throughout. in_valid with new data while busy is not accepted. Transfer on out_ready=1, then next word accepted.
- Assert rst_n=0 asynchronously mid-SCAN of 0x7F -> outputs 0 immediately with no clock edge required. After release, 0x40 converts to 1 normally.
